// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_3000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x 64-bit instruction buffer with push, pop and flush
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [63:0]              head_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_eff;
  logic          pop_eff;

  // Flush wins over everything; a pop on an empty buffer is ignored.
  assign push_eff = push & ~flush;
  assign pop_eff  = pop & valid & ~flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_eff)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign valid     = (count != '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM between PC register, instruction memory and decode
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] pc_addr,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  addr_nxt;
  logic [31:0]  pc_plus4;
  logic         push;
  logic         pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [63:0]  head_data;

  assign pc_plus4 = pc_addr + INSTR_BYTES;

  // A redirect flushes the buffer, so decode must not consume in that cycle.
  assign pop = inst_valid & inst_ready & ~redirect_valid;

  // Occupancy after this cycle's push, accounting for a coincident pop.
  assign count_after = count + CNT_ONE - (pop ? CNT_ONE : '0);

  assign push_entry = '{pc: imem_addr, instr: imem_rdata};
  assign head_entry = fetch_entry_t'(head_data);

  // State register and the held request address.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      imem_addr <= addr_nxt;
    end
  end

  // Next-state, request address and push decisions.
  always_comb begin
    state_nxt = state;
    addr_nxt  = imem_addr;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!redirect_valid && (count < DEPTH_C)) begin
          state_nxt = ST_REQ;
          addr_nxt  = pc_addr;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          state_nxt = imem_ack ? ST_IDLE : ST_DROP;
        end else if (imem_ack) begin
          push = 1'b1;
          if (count_after < DEPTH_C) begin
            state_nxt = ST_REQ;
            addr_nxt  = pc_plus4;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (imem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address handed back to the PC register.
  always_comb begin
    next_pc = pc_addr;
    if (!Reset)
      next_pc = RESET_PC;
    else if (redirect_valid)
      next_pc = align_word(redirect_target);
    else if ((state == ST_REQ) && imem_ack)
      next_pc = pc_plus4;
  end

  assign imem_req = (state == ST_REQ) || (state == ST_DROP);

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .valid     (inst_valid),
    .count     (count)
  );

  assign inst_data = head_entry.instr;
  assign inst_pc   = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] pc_addr = 32'h0000_3000;
  logic [31:0] next_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .pc_addr         (pc_addr),
    .next_pc         (next_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  always #5 CLK = ~CLK;

  // PC register model: loads whatever the fetch unit hands back.
  always @(posedge CLK) pc_addr <= next_pc;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int ready_pct = 100;
  int redir_pct = 0;
  int wait_cnt  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc = 32'h0000_3000;
  logic        tainted  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 3) == 0)
      return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'h0000_4000 + 32'($urandom_range(0, 255));
  endfunction

  // Monitor: compares the buffer head against the scoreboard whenever decode consumes.
  always @(negedge CLK) begin
    logic [63:0] e;
    if (!Reset) begin
      check("reset_imem_req", 32'(imem_req), 32'd0);
      check("reset_inst_valid", 32'(inst_valid), 32'd0);
      check("reset_next_pc", next_pc, 32'h0000_3000);
    end else begin
      check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
      if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e[63:32]);
        check("inst_data", inst_data, e[31:0]);
        pops++;
      end
    end
  end

  // Reference model: architectural fetch PC, request poisoning by redirects, buffer contents.
  always @(negedge CLK) begin
    logic        accept;
    logic [31:0] exp_next;
    #1;
    if (!Reset) begin
      exp_q.delete();
      model_pc = 32'h0000_3000;
      tainted  = 1'b0;
    end else begin
      accept   = imem_ack && imem_req && !tainted && !redirect_valid;
      exp_next = redirect_valid ? {redirect_target[31:2], 2'b00}
               : accept ? model_pc + 32'd4 : model_pc;
      check("next_pc", next_pc, exp_next);
      if (redirect_valid) exp_q.delete();
      if (accept) exp_q.push_back({model_pc, mem_word(model_pc)});
      if (imem_ack && imem_req) tainted = 1'b0;
      else if (redirect_valid && imem_req) tainted = 1'b1;
      model_pc = exp_next;
    end
  end

  // One cycle of stimulus; ack_mode 0 = random latency, 1 = ack now, 2 = hold off.
  task automatic drive_cycle(input logic force_redir, input logic [31:0] force_tgt, input int ack_mode);
    logic ack;
    @(posedge CLK);
    #1;
    inst_ready = ($urandom_range(0, 99) < ready_pct);
    if (force_redir) begin
      redirect_valid  = 1'b1;
      redirect_target = force_tgt;
    end else begin
      redirect_valid  = ($urandom_range(0, 99) < redir_pct);
      redirect_target = rand_target();
    end
    if (imem_req) begin
      ack = (ack_mode == 1) ||
            (ack_mode == 0 && (wait_cnt >= 3 || $urandom_range(0, 1) == 1));
      wait_cnt = ack ? 0 : wait_cnt + 1;
    end else begin
      ack = 1'b0;
      wait_cnt = 0;
    end
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(imem_addr) : $urandom();
  endtask

  task automatic wait_req();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      drive_cycle(1'b0, 32'h0, 2);
      if (imem_req) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_req: imem_req stayed %0d for 20 cycles, required 1", imem_req);
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_next_pc", next_pc, 32'h0000_3000);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0000_3000);

    // Zero-wait streaming.
    ready_pct = 100;
    redir_pct = 0;
    repeat (8) drive_cycle(1'b0, 32'h0, 1);

    // Backpressure fills the buffer and stalls fetch.
    ready_pct = 0;
    repeat (8) drive_cycle(1'b0, 32'h0, 1);
    check("bp_idle", 32'(imem_req), 32'd0);
    check("bp_full", 32'(inst_valid), 32'd1);
    ready_pct = 100;
    repeat (6) drive_cycle(1'b0, 32'h0, 1);

    // Redirect while a request is outstanding, late ack arrives in DROP.
    wait_req();
    drive_cycle(1'b1, 32'h0000_4000, 2);
    repeat (2) drive_cycle(1'b0, 32'h0, 2);
    drive_cycle(1'b0, 32'h0, 1);
    wait_req();
    check("redir_addr", imem_addr, 32'h0000_4000);

    // Redirect coincident with ack, unaligned target.
    wait_req();
    drive_cycle(1'b1, 32'h0000_4002, 1);
    check("coinc_next_pc", next_pc, 32'h0000_4000);
    wait_req();
    check("coinc_addr", imem_addr, 32'h0000_4000);

    // Randomized traffic.
    ready_pct = 70;
    redir_pct = 8;
    repeat (400) drive_cycle(1'b0, 32'h0, 0);

    // Asynchronous reset between edges with a request outstanding and data buffered.
    redir_pct = 0;
    ready_pct = 0;
    wait_req();
    drive_cycle(1'b0, 32'h0, 1);
    drive_cycle(1'b0, 32'h0, 2);
    #2;
    Reset = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_valid", 32'(inst_valid), 32'd0);
    repeat (2) begin
      @(posedge CLK);
      #1;
      redirect_valid = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = $urandom();
    end
    @(posedge CLK);
    #1;
    Reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = $urandom();
    @(posedge CLK);
    #1;
    check("late_ack_ignored", 32'(inst_valid), 32'd0);
    check("post_reset_addr", imem_addr, 32'h0000_3000);
    imem_ack = 1'b0;

    ready_pct = 80;
    redir_pct = 5;
    repeat (150) drive_cycle(1'b0, 32'h0, 0);
    ready_pct = 100;
    redir_pct = 0;
    repeat (10) drive_cycle(1'b0, 32'h0, 2);

    check("progress", 32'(pops >= 30), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
